systolic_array_nxn: RTL and testbench

Parametrised N×N output-stationary systolic matrix-multiply engine; the successor to the fixed 2×2 array in the TPU datapath. Computes C = A·B for an N×K by K×N operand pair streamed one K-slice per beat, with internal input skewing, a valid/ready input handshake, a load/flush/drain controller, signed or unsigned arithmetic, and a row-serial result port. It sits between the operand buffers and the accumulator/writeback stage.

---
 rtl/systolic_array_nxn.sv | 253 +++++++++++++++++++++++++
 tb/tb_systolic_array_nxn.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_nxn.sv
// N x N output-stationary systolic matrix-multiply engine with input skewing,
// a valid/ready operand port, a LOAD/FLUSH/DRAIN controller and row-serial results.
module systolic_array_nxn #(
  parameter int N         = 2,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int KW        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   signed_mode,
  input  logic [N*WIDTH-1:0]     a_in,
  input  logic [N*WIDTH-1:0]     b_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N*ACC_WIDTH-1:0] out_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int FW = $clog2(2 * N);
  localparam int RW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [KW-1:0]   beat_q, beat_d;
  logic            signed_q, signed_d;
  logic [FW-1:0]   flush_q, flush_d;
  logic [RW-1:0]   row_q, row_d;
  logic            clear;
  logic            advance;

  function automatic logic [ACC_WIDTH-1:0] extend(input logic [WIDTH-1:0] v, input logic s);
    extend = s ? {{(ACC_WIDTH-WIDTH){v[WIDTH-1]}}, v} : {{(ACC_WIDTH-WIDTH){1'b0}}, v};
  endfunction

  always_comb begin
    state_d   = state_q;
    k_len_d   = k_len_q;
    beat_d    = beat_q;
    signed_d  = signed_q;
    flush_d   = flush_q;
    row_d     = row_q;
    clear     = 1'b0;
    advance   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (k_len != '0)) begin
          clear    = 1'b1;
          k_len_d  = k_len;
          signed_d = signed_mode;
          beat_d   = '0;
          flush_d  = '0;
          row_d    = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          advance = 1'b1;
          beat_d  = beat_q + KW'(1);
          if ((beat_q + KW'(1)) == k_len_q) begin
            flush_d = '0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // 2N-1 zero beats push the last real slice through to PE(N-1,N-1)
        advance = 1'b1;
        flush_d = flush_q + FW'(1);
        if (flush_q == FW'(2 * N - 2)) begin
          row_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (row_q == RW'(N - 1));
        if (out_ready) begin
          if (row_q == RW'(N - 1)) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      k_len_q  <= '0;
      beat_q   <= '0;
      signed_q <= 1'b0;
      flush_q  <= '0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_len_q  <= k_len_d;
      beat_q   <= beat_d;
      signed_q <= signed_d;
      flush_q  <= flush_d;
      row_q    <= row_d;
    end
  end

  assign busy = (state_q != IDLE);

  logic [WIDTH-1:0] a_src  [N];
  logic [WIDTH-1:0] b_src  [N];
  logic [WIDTH-1:0] a_edge [N];
  logic [WIDTH-1:0] b_edge [N];

  // Row i of A and column i of B each pass through an i-deep shift register
  for (genvar i = 0; i < N; i++) begin : g_skew
    assign a_src[i] = (state_q == LOAD) ? a_in[i*WIDTH +: WIDTH] : '0;
    assign b_src[i] = (state_q == LOAD) ? b_in[i*WIDTH +: WIDTH] : '0;
    if (i == 0) begin : g_direct
      assign a_edge[i] = a_src[i];
      assign b_edge[i] = b_src[i];
    end else begin : g_delay
      logic [WIDTH-1:0] a_sr_q [i];
      logic [WIDTH-1:0] a_sr_d [i];
      logic [WIDTH-1:0] b_sr_q [i];
      logic [WIDTH-1:0] b_sr_d [i];

      always_comb begin
        a_sr_d = a_sr_q;
        b_sr_d = b_sr_q;
        if (clear) begin
          for (int s = 0; s < i; s++) begin
            a_sr_d[s] = '0;
            b_sr_d[s] = '0;
          end
        end else if (advance) begin
          a_sr_d[0] = a_src[i];
          b_sr_d[0] = b_src[i];
          for (int s = 1; s < i; s++) begin
            a_sr_d[s] = a_sr_q[s-1];
            b_sr_d[s] = b_sr_q[s-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < i; s++) begin
            a_sr_q[s] <= '0;
            b_sr_q[s] <= '0;
          end
        end else begin
          a_sr_q <= a_sr_d;
          b_sr_q <= b_sr_d;
        end
      end

      assign a_edge[i] = a_sr_q[i-1];
      assign b_edge[i] = b_sr_q[i-1];
    end
  end

  logic [WIDTH-1:0]     a_left [N][N];
  logic [WIDTH-1:0]     b_up   [N][N];
  logic [WIDTH-1:0]     pa_q   [N][N-1];
  logic [WIDTH-1:0]     pa_d   [N][N-1];
  logic [WIDTH-1:0]     pb_q   [N-1][N];
  logic [WIDTH-1:0]     pb_d   [N-1][N];
  logic [ACC_WIDTH-1:0] acc_q  [N][N];
  logic [ACC_WIDTH-1:0] acc_d  [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_left[i][j] = a_edge[i];
      end else begin : g_a_fwd
        assign a_left[i][j] = pa_q[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_up[i][j] = b_edge[j];
      end else begin : g_b_fwd
        assign b_up[i][j] = pb_q[i-1][j];
      end
    end
  end

  // Operand registers exist only where a neighbour consumes them
  always_comb begin
    pa_d  = pa_q;
    pb_d  = pb_q;
    acc_d = acc_q;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (clear) begin
          acc_d[i][j] = '0;
        end else if (advance) begin
          acc_d[i][j] = acc_q[i][j] + extend(a_left[i][j], signed_q) * extend(b_up[i][j], signed_q);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N - 1; j++) begin
        if (clear) pa_d[i][j] = '0;
        else if (advance) pa_d[i][j] = a_left[i][j];
      end
    end
    for (int i = 0; i < N - 1; i++) begin
      for (int j = 0; j < N; j++) begin
        if (clear) pb_d[i][j] = '0;
        else if (advance) pb_d[i][j] = b_up[i][j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) acc_q[i][j] <= '0;
        for (int j = 0; j < N - 1; j++) pa_q[i][j] <= '0;
      end
      for (int i = 0; i < N - 1; i++) begin
        for (int j = 0; j < N; j++) pb_q[i][j] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      pa_q  <= pa_d;
      pb_q  <= pb_d;
    end
  end

  always_comb begin
    out_row = '0;
    if (state_q == DRAIN) begin
      for (int j = 0; j < N; j++) out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[row_q][j];
    end
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Directed bench: a 2x2 16-bit-accumulator instance and a 4x4 signed instance,
// with hand-computed products, bubbles, backpressure, reset abort and wrap cases.
module tb_systolic_array_nxn;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start2, sgn2, in_valid2, in_ready2, out_valid2, out_ready2, out_last2, busy2, done2;
  logic [7:0]  klen2;
  logic [15:0] a_in2, b_in2;
  logic [31:0] out_row2;

  logic        start4, sgn4, in_valid4, in_ready4, out_valid4, out_ready4, out_last4, busy4, done4;
  logic [7:0]  klen4;
  logic [31:0] a_in4, b_in4;
  logic [95:0] out_row4;

  systolic_array_nxn #(.N(2), .WIDTH(8), .ACC_WIDTH(16), .KW(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .k_len(klen2), .signed_mode(sgn2),
    .a_in(a_in2), .b_in(b_in2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_row(out_row2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_last(out_last2), .busy(busy2), .done(done2));

  systolic_array_nxn #(.N(4), .WIDTH(8), .ACC_WIDTH(24), .KW(8)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .k_len(klen4), .signed_mode(sgn4),
    .a_in(a_in4), .b_in(b_in4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_row(out_row4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_last(out_last4), .busy(busy4), .done(done4));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt2 = 0;
  int done_cnt4 = 0;

  logic [7:0]  a2 [8][2];
  logic [7:0]  b2 [8][2];
  logic [31:0] rows2 [2];
  logic        lasts2 [2];
  logic [7:0]  a4 [4][4];
  logic [7:0]  b4 [4][4];
  logic [95:0] rows4 [4];
  logic        lasts4 [4];
  int nrows, t_last, t_valid, unstable, ready_drop, timeout, done_row;

  int bv [4][4] = '{'{-128, 127, -1, 0}, '{1, 2, 3, 4}, '{100, -100, 50, -50}, '{127, -128, 7, -7}};

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done2 === 1'b1) done_cnt2 <= done_cnt2 + 1;
    if (done4 === 1'b1) done_cnt4 <= done_cnt4 + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Runs one job on the 2x2 instance; vpat/rpat give per-cycle in_valid/out_ready
  task automatic job2(input int k, input logic sgn, input logic [31:0] vpat, input logic [31:0] rpat);
    int bi, lc, dc;
    logic [31:0] hold_row;
    logic hold_last, holding;
    nrows = 0; t_last = -1; t_valid = -1; unstable = 0; ready_drop = 0; timeout = 0; done_row = -1;
    @(posedge clk); #1;
    start2 = 1'b1; klen2 = 8'(k); sgn2 = sgn;
    @(posedge clk); #1;
    start2 = 1'b0;
    bi = 0; lc = 0;
    while (bi < k && lc < 100) begin
      in_valid2 = (lc < 32) ? vpat[lc] : 1'b1;
      a_in2 = in_valid2 ? {a2[bi][1], a2[bi][0]} : 16'hA5C3;
      b_in2 = in_valid2 ? {b2[bi][1], b2[bi][0]} : 16'h3C5A;
      @(negedge clk);
      if (!in_ready2) ready_drop++;
      if (in_valid2 && in_ready2) begin
        bi++;
        if (bi == k) t_last = cyc;
      end
      @(posedge clk); #1;
      lc++;
    end
    in_valid2 = 1'b0; a_in2 = 16'hFFFF; b_in2 = 16'hFFFF;
    if (bi < k) timeout = 1;
    dc = 0; holding = 1'b0; hold_row = '0; hold_last = 1'b0;
    while (nrows < 2 && dc < 100) begin
      out_ready2 = (dc < 32) ? rpat[dc] : 1'b1;
      @(negedge clk);
      if (out_valid2) begin
        if (t_valid < 0) t_valid = cyc;
        if (holding && (out_row2 !== hold_row || out_last2 !== hold_last)) unstable++;
        if (out_ready2) begin
          if (done2) done_row = nrows;
          rows2[nrows] = out_row2;
          lasts2[nrows] = out_last2;
          nrows++;
          holding = 1'b0;
        end else begin
          holding = 1'b1; hold_row = out_row2; hold_last = out_last2;
        end
      end
      @(posedge clk); #1;
      dc++;
    end
    out_ready2 = 1'b0;
    if (nrows < 2) timeout = 1;
  endtask

  task automatic job4(input logic sgn);
    int bi, lc, dc;
    nrows = 0; timeout = 0;
    @(posedge clk); #1;
    start4 = 1'b1; klen4 = 8'd4; sgn4 = sgn;
    @(posedge clk); #1;
    start4 = 1'b0;
    bi = 0; lc = 0;
    while (bi < 4 && lc < 50) begin
      in_valid4 = 1'b1;
      for (int i = 0; i < 4; i++) begin
        a_in4[i*8 +: 8] = a4[bi][i];
        b_in4[i*8 +: 8] = b4[bi][i];
      end
      @(negedge clk);
      if (in_ready4) bi++;
      @(posedge clk); #1;
      lc++;
    end
    in_valid4 = 1'b0; out_ready4 = 1'b1; dc = 0;
    while (nrows < 4 && dc < 100) begin
      @(negedge clk);
      if (out_valid4) begin
        rows4[nrows] = out_row4;
        lasts4[nrows] = out_last4;
        nrows++;
      end
      @(posedge clk); #1;
      dc++;
    end
    out_ready4 = 1'b0;
    if (bi < 4 || nrows < 4) timeout = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start2 = 0; klen2 = 0; sgn2 = 0; a_in2 = 0; b_in2 = 0; in_valid2 = 0; out_ready2 = 0;
    start4 = 0; klen4 = 0; sgn4 = 0; a_in4 = 0; b_in4 = 0; in_valid4 = 0; out_ready4 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready2 !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready got %b expected 0", in_ready2); end
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got %b expected 0", out_valid2); end
    checks++; if (out_last2 !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_last got %b expected 0", out_last2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b expected 0", busy2); end
    checks++; if (done2 !== 1'b0) begin errors++; $display("[TB] FAIL rst_done got %b expected 0", done2); end
    checks++; if (out_row2 !== 32'h0) begin errors++; $display("[TB] FAIL rst_out_row got %h expected 0", out_row2); end
    checks++; if (out_row4 !== 96'h0) begin errors++; $display("[TB] FAIL rst_out_row4 got %h expected 0", out_row4); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic load_basic();
    a2[0][0] = 8'd1; a2[0][1] = 8'd3; a2[1][0] = 8'd2; a2[1][1] = 8'd4;
    b2[0][0] = 8'd5; b2[0][1] = 8'd6; b2[1][0] = 8'd7; b2[1][1] = 8'd8;
  endtask

  task automatic test_basic();
    int dc0;
    load_basic();
    dc0 = done_cnt2;
    job2(2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (timeout !== 0) begin errors++; $display("[TB] FAIL basic_timeout got %0d expected 0", timeout); end
    checks++; if (rows2[0] !== {16'd22, 16'd19}) begin errors++; $display("[TB] FAIL basic_row0 got %h expected %h", rows2[0], {16'd22, 16'd19}); end
    checks++; if (rows2[1] !== {16'd50, 16'd43}) begin errors++; $display("[TB] FAIL basic_row1 got %h expected %h", rows2[1], {16'd50, 16'd43}); end
    checks++; if (t_valid - t_last !== 4) begin errors++; $display("[TB] FAIL basic_latency got %0d expected 4", t_valid - t_last); end
    checks++; if (ready_drop !== 0) begin errors++; $display("[TB] FAIL basic_in_ready_drop got %0d expected 0", ready_drop); end
    checks++; if (lasts2[0] !== 1'b0 || lasts2[1] !== 1'b1) begin errors++; $display("[TB] FAIL basic_last got %b%b expected 01", lasts2[0], lasts2[1]); end
    checks++; if (done_row !== 1) begin errors++; $display("[TB] FAIL basic_done_row got %0d expected 1", done_row); end
    @(negedge clk);
    checks++; if (done_cnt2 - dc0 !== 1) begin errors++; $display("[TB] FAIL basic_done_count got %0d expected 1", done_cnt2 - dc0); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_busy got %b expected 0", busy2); end
  endtask

  task automatic test_bubbles();
    a2[0][0] = 8'd1; a2[0][1] = 8'd4; a2[1][0] = 8'd2; a2[1][1] = 8'd5; a2[2][0] = 8'd3; a2[2][1] = 8'd6;
    b2[0][0] = 8'd7; b2[0][1] = 8'd8; b2[1][0] = 8'd9; b2[1][1] = 8'd10; b2[2][0] = 8'd11; b2[2][1] = 8'd12;
    job2(3, 1'b0, 32'h0000_0029, 32'hFFFF_FFFF);
    checks++; if (timeout !== 0) begin errors++; $display("[TB] FAIL bubble_timeout got %0d expected 0", timeout); end
    checks++; if (rows2[0] !== {16'd64, 16'd58}) begin errors++; $display("[TB] FAIL bubble_row0 got %h expected %h", rows2[0], {16'd64, 16'd58}); end
    checks++; if (rows2[1] !== {16'd154, 16'd139}) begin errors++; $display("[TB] FAIL bubble_row1 got %h expected %h", rows2[1], {16'd154, 16'd139}); end
    checks++; if (ready_drop !== 0) begin errors++; $display("[TB] FAIL bubble_early_flush got %0d expected 0", ready_drop); end
    checks++; if (t_valid - t_last !== 4) begin errors++; $display("[TB] FAIL bubble_latency got %0d expected 4", t_valid - t_last); end
  endtask

  task automatic test_backpressure();
    int dc0;
    load_basic();
    dc0 = done_cnt2;
    job2(2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0500);
    checks++; if (timeout !== 0) begin errors++; $display("[TB] FAIL bp_timeout got %0d expected 0", timeout); end
    checks++; if (rows2[0] !== {16'd22, 16'd19}) begin errors++; $display("[TB] FAIL bp_row0 got %h expected %h", rows2[0], {16'd22, 16'd19}); end
    checks++; if (rows2[1] !== {16'd50, 16'd43}) begin errors++; $display("[TB] FAIL bp_row1 got %h expected %h", rows2[1], {16'd50, 16'd43}); end
    checks++; if (unstable !== 0) begin errors++; $display("[TB] FAIL bp_hold_stable got %0d expected 0", unstable); end
    checks++; if (lasts2[0] !== 1'b0 || lasts2[1] !== 1'b1) begin errors++; $display("[TB] FAIL bp_last got %b%b expected 01", lasts2[0], lasts2[1]); end
    checks++; if (done_row !== 1) begin errors++; $display("[TB] FAIL bp_done_row got %0d expected 1", done_row); end
    @(negedge clk);
    checks++; if (done_cnt2 - dc0 !== 1) begin errors++; $display("[TB] FAIL bp_done_count got %0d expected 1", done_cnt2 - dc0); end
  endtask

  task automatic test_zero_klen();
    @(posedge clk); #1;
    start2 = 1'b1; klen2 = 8'd0;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(negedge clk);
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL zero_klen_busy got %b expected 0", busy2); end
    checks++; if (in_ready2 !== 1'b0) begin errors++; $display("[TB] FAIL zero_klen_ready got %b expected 0", in_ready2); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 2; k++) begin
      a2[k][0] = 8'd255; a2[k][1] = 8'd255; b2[k][0] = 8'd255; b2[k][1] = 8'd255;
    end
    job2(2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (rows2[0] !== {16'd64514, 16'd64514}) begin errors++; $display("[TB] FAIL wrap_row0 got %h expected %h", rows2[0], {16'd64514, 16'd64514}); end
    checks++; if (rows2[1] !== {16'd64514, 16'd64514}) begin errors++; $display("[TB] FAIL wrap_row1 got %h expected %h", rows2[1], {16'd64514, 16'd64514}); end
  endtask

  task automatic test_reset_abort();
    int dc0;
    dc0 = done_cnt2;
    @(posedge clk); #1;
    start2 = 1'b1; klen2 = 8'd2; sgn2 = 1'b0;
    @(posedge clk); #1;
    start2 = 1'b0; in_valid2 = 1'b1; a_in2 = {8'd9, 8'd9}; b_in2 = {8'd9, 8'd9};
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b expected 0", busy2); end
    checks++; if (in_ready2 !== 1'b0) begin errors++; $display("[TB] FAIL abort_ready got %b expected 0", in_ready2); end
    @(posedge clk); #1;
    rst = 1'b1;
    checks++; if (done_cnt2 - dc0 !== 0) begin errors++; $display("[TB] FAIL abort_no_done got %0d expected 0", done_cnt2 - dc0); end
    a2[0][0] = 8'd2; a2[0][1] = 8'd3; b2[0][0] = 8'd4; b2[0][1] = 8'd5;
    job2(1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (rows2[0] !== {16'd10, 16'd8}) begin errors++; $display("[TB] FAIL abort_row0 got %h expected %h", rows2[0], {16'd10, 16'd8}); end
    checks++; if (rows2[1] !== {16'd15, 16'd12}) begin errors++; $display("[TB] FAIL abort_row1 got %h expected %h", rows2[1], {16'd15, 16'd12}); end
    @(negedge clk);
    checks++; if (done_cnt2 - dc0 !== 1) begin errors++; $display("[TB] FAIL abort_done_count got %0d expected 1", done_cnt2 - dc0); end
  endtask

  task automatic test_signed_n4();
    logic [95:0] expv;
    int dc0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        a4[k][i] = (i == k) ? 8'd1 : 8'd0;
        b4[k][i] = 8'(bv[k][i]);
      end
    end
    dc0 = done_cnt4;
    job4(1'b1);
    checks++; if (timeout !== 0) begin errors++; $display("[TB] FAIL n4_timeout got %0d expected 0", timeout); end
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) expv[j*24 +: 24] = 24'(bv[r][j]);
      checks++; if (rows4[r] !== expv) begin errors++; $display("[TB] FAIL n4_identity_row%0d got %h expected %h", r, rows4[r], expv); end
    end
    checks++; if (lasts4[2] !== 1'b0 || lasts4[3] !== 1'b1) begin errors++; $display("[TB] FAIL n4_last got %b%b expected 01", lasts4[2], lasts4[3]); end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        a4[k][i] = 8'hFF;
        b4[k][i] = 8'hFF;
      end
    end
    job4(1'b1);
    expv = {24'd4, 24'd4, 24'd4, 24'd4};
    for (int r = 0; r < 4; r++) begin
      checks++; if (rows4[r] !== expv) begin errors++; $display("[TB] FAIL n4_neg_row%0d got %h expected %h", r, rows4[r], expv); end
    end
    @(negedge clk);
    checks++; if (done_cnt4 - dc0 !== 2) begin errors++; $display("[TB] FAIL n4_done_count got %0d expected 2", done_cnt4 - dc0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_backpressure();
    test_zero_klen();
    test_wrap();
    test_reset_abort();
    test_signed_n4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
